// File: rtl/ptw_req_arbiter.sv
// ptw_req_arbiter: shares one page-table walker between the ITLB and the DTLB.
// Each requester owns a one-entry pending slot. One slot is picked per walk,
// with DTLB priority and an ITLB anti-starvation limit. The walk result is
// routed back to the TLB that asked for it. A flush drops both slots, and a
// walk that is already in flight is drained without producing a response.
//
// Handshakes: a requester miss is captured when req_valid_i & req_ready_o are
// both high at a rising edge. walk_req_o stays high, with the walk fields held
// stable, until walk_gnt_i is seen at a rising edge. walk_done_i/walk_err_i are
// single-cycle and are only honoured while a walk is outstanding.
module ptw_req_arbiter #(
   parameter int unsigned VLEN         = 39,
   parameter int unsigned ASID_WIDTH   = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  itlb_req_valid_i,
   output logic                  itlb_req_ready_o,
   input  logic [VLEN-1:0]       itlb_vaddr_i,
   input  logic [ASID_WIDTH-1:0] itlb_asid_i,
   input  logic                  dtlb_req_valid_i,
   output logic                  dtlb_req_ready_o,
   input  logic [VLEN-1:0]       dtlb_vaddr_i,
   input  logic [ASID_WIDTH-1:0] dtlb_asid_i,
   input  logic                  dtlb_is_store_i,
   output logic                  walk_req_o,
   input  logic                  walk_gnt_i,
   output logic                  walk_is_instr_o,
   output logic [VLEN-1:0]       walk_vaddr_o,
   output logic [ASID_WIDTH-1:0] walk_asid_o,
   output logic                  walk_is_store_o,
   input  logic                  walk_done_i,
   input  logic                  walk_err_i,
   output logic                  itlb_resp_o,
   output logic                  dtlb_resp_o,
   output logic                  resp_err_o,
   output logic                  busy_o
);

   localparam int unsigned   CW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WALK  = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic                  sel_instr_q, sel_instr_d;
   logic [CW-1:0]         starve_cnt_q, starve_cnt_d;

   logic                  itlb_full_q, itlb_full_d;
   logic [VLEN-1:0]       itlb_vaddr_q, itlb_vaddr_d;
   logic [ASID_WIDTH-1:0] itlb_asid_q, itlb_asid_d;
   logic                  dtlb_full_q, dtlb_full_d;
   logic [VLEN-1:0]       dtlb_vaddr_q, dtlb_vaddr_d;
   logic [ASID_WIDTH-1:0] dtlb_asid_q, dtlb_asid_d;
   logic                  dtlb_store_q, dtlb_store_d;

   logic                  itlb_cap, dtlb_cap;
   logic                  itlb_pend, dtlb_pend;
   logic                  grant;
   logic                  walk_finish;

   // Capture conditions and arbitration view of the slots. A miss that is
   // being captured this cycle already counts as pending, so arbitration
   // costs a single cycle from the request to walk_req_o.
   always_comb begin
      itlb_req_ready_o = !itlb_full_q && !flush_i;
      dtlb_req_ready_o = !dtlb_full_q && !flush_i;
      itlb_cap         = itlb_req_valid_i && itlb_req_ready_o;
      dtlb_cap         = dtlb_req_valid_i && dtlb_req_ready_o;
      itlb_pend        = itlb_full_q || itlb_cap;
      dtlb_pend        = dtlb_full_q || dtlb_cap;
      grant            = (state_q == S_REQ) && walk_gnt_i;
      walk_finish      = (state_q == S_WALK) && walk_done_i && !flush_i;
   end

   // Slot next-state: flush empties both slots, a finished walk frees its slot,
   // and an accepted miss fills an empty slot.
   always_comb begin
      itlb_full_d  = itlb_full_q;
      itlb_vaddr_d = itlb_vaddr_q;
      itlb_asid_d  = itlb_asid_q;
      dtlb_full_d  = dtlb_full_q;
      dtlb_vaddr_d = dtlb_vaddr_q;
      dtlb_asid_d  = dtlb_asid_q;
      dtlb_store_d = dtlb_store_q;
      if (flush_i) begin
         itlb_full_d = 1'b0;
         dtlb_full_d = 1'b0;
      end else begin
         if (walk_finish) begin
            if (sel_instr_q) itlb_full_d = 1'b0;
            else             dtlb_full_d = 1'b0;
         end
         if (itlb_cap) begin
            itlb_full_d  = 1'b1;
            itlb_vaddr_d = itlb_vaddr_i;
            itlb_asid_d  = itlb_asid_i;
         end
         if (dtlb_cap) begin
            dtlb_full_d  = 1'b1;
            dtlb_vaddr_d = dtlb_vaddr_i;
            dtlb_asid_d  = dtlb_asid_i;
            dtlb_store_d = dtlb_is_store_i;
         end
      end
   end

   // Walk FSM next-state and selection; flush overrides every other transition.
   always_comb begin
      state_d     = state_q;
      sel_instr_d = sel_instr_q;
      if (flush_i) begin
         case (state_q)
            S_REQ:   state_d = walk_gnt_i  ? S_DRAIN : S_IDLE;
            S_WALK:  state_d = walk_done_i ? S_IDLE  : S_DRAIN;
            S_DRAIN: state_d = walk_done_i ? S_IDLE  : S_DRAIN;
            default: state_d = S_IDLE;
         endcase
      end else begin
         case (state_q)
            S_IDLE: begin
               if (itlb_pend || dtlb_pend) begin
                  sel_instr_d = itlb_pend && (!dtlb_pend || (starve_cnt_q == LIMIT));
                  state_d     = S_REQ;
               end
            end
            S_REQ:   if (walk_gnt_i)  state_d = S_WALK;
            S_WALK:  if (walk_done_i) state_d = S_IDLE;
            S_DRAIN: if (walk_done_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Starvation counter: consecutive DTLB grants while the ITLB waits.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant) begin
         if (sel_instr_q)                starve_cnt_d = '0;
         else if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + CW'(1);
      end
      if (flush_i || !itlb_full_q) starve_cnt_d = '0;
   end

   // Walker-side and TLB-side outputs, decoded from state and selected slot.
   always_comb begin
      walk_req_o      = (state_q == S_REQ);
      walk_is_instr_o = walk_req_o && sel_instr_q;
      walk_is_store_o = walk_req_o && !sel_instr_q && dtlb_store_q;
      walk_vaddr_o    = '0;
      walk_asid_o     = '0;
      if (walk_req_o) begin
         walk_vaddr_o = sel_instr_q ? itlb_vaddr_q : dtlb_vaddr_q;
         walk_asid_o  = sel_instr_q ? itlb_asid_q  : dtlb_asid_q;
      end
      itlb_resp_o = walk_finish && sel_instr_q;
      dtlb_resp_o = walk_finish && !sel_instr_q;
      resp_err_o  = walk_finish && walk_err_i;
      busy_o      = (state_q != S_IDLE);
   end

   // State, selection, counter and slot registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         sel_instr_q  <= 1'b0;
         starve_cnt_q <= '0;
         itlb_full_q  <= 1'b0;
         itlb_vaddr_q <= '0;
         itlb_asid_q  <= '0;
         dtlb_full_q  <= 1'b0;
         dtlb_vaddr_q <= '0;
         dtlb_asid_q  <= '0;
         dtlb_store_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_instr_q  <= sel_instr_d;
         starve_cnt_q <= starve_cnt_d;
         itlb_full_q  <= itlb_full_d;
         itlb_vaddr_q <= itlb_vaddr_d;
         itlb_asid_q  <= itlb_asid_d;
         dtlb_full_q  <= dtlb_full_d;
         dtlb_vaddr_q <= dtlb_vaddr_d;
         dtlb_asid_q  <= dtlb_asid_d;
         dtlb_store_q <= dtlb_store_d;
      end
   end

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// Bench for ptw_req_arbiter: directed scenarios with literal expectations plus
// a transaction-level reference model compared against the DUT every cycle.
module tb_ptw_req_arbiter;

   localparam int VLEN  = 39;
   localparam int LIMIT = 4;

   // clock / reset block
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst = 1'b1, flush = 1'b0;
   logic            iv = 1'b0, dv = 1'b0, dst = 1'b0;
   logic [VLEN-1:0] iva = '0, dva = '0;
   logic            ias = 1'b0, das = 1'b0;
   logic            gnt = 1'b0, done = 1'b0, werr = 1'b0;

   logic            irdy, drdy, wreq, winstr, wstore, ires, dres, rerr, busy;
   logic [VLEN-1:0] wva;
   logic            was;

   ptw_req_arbiter #(.VLEN(VLEN), .ASID_WIDTH(1), .STARVE_LIMIT(LIMIT)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .itlb_req_valid_i(iv), .itlb_req_ready_o(irdy), .itlb_vaddr_i(iva), .itlb_asid_i(ias),
      .dtlb_req_valid_i(dv), .dtlb_req_ready_o(drdy), .dtlb_vaddr_i(dva), .dtlb_asid_i(das),
      .dtlb_is_store_i(dst),
      .walk_req_o(wreq), .walk_gnt_i(gnt), .walk_is_instr_o(winstr), .walk_vaddr_o(wva),
      .walk_asid_o(was), .walk_is_store_o(wstore), .walk_done_i(done), .walk_err_i(werr),
      .itlb_resp_o(ires), .dtlb_resp_o(dres), .resp_err_o(rerr), .busy_o(busy)
   );

   int total = 0;
   int bad   = 0;
   int i_cnt = 0;
   int d_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // Requester index: 0 = DTLB, 1 = ITLB. phase: 0 idle, 1 requesting,
   // 2 walk outstanding for a live slot, 3 walk outstanding but abandoned.
   bit              m_on = 1'b0;
   bit              m_full[2];
   logic [VLEN-1:0] m_va[2];
   logic            m_as[2];
   bit              m_st;
   int              m_phase, m_sel, m_cnt;

   always @(posedge clk) begin : model_step
      bit cap[2];
      bit eff[2];
      bit fin;
      int nph;
      if (rst) begin
         m_on = 1'b1;
         m_full[0] = 0; m_full[1] = 0;
         m_va[0] = '0; m_va[1] = '0; m_as[0] = 0; m_as[1] = 0; m_st = 0;
         m_phase = 0; m_sel = 0; m_cnt = 0;
      end else if (m_on) begin
         cap[0] = dv && !m_full[0] && !flush;
         cap[1] = iv && !m_full[1] && !flush;
         eff[0] = m_full[0] || cap[0];
         eff[1] = m_full[1] || cap[1];
         fin = (m_phase == 2) && done && !flush;
         // DTLB grants while the ITLB waits are counted; ITLB grant resets it
         if (m_phase == 1 && gnt) begin
            if (m_sel == 1) m_cnt = 0;
            else if (m_cnt < LIMIT) m_cnt = m_cnt + 1;
         end
         nph = m_phase;
         if (flush) begin
            if ((m_phase == 1 && gnt) || (m_phase >= 2 && !done)) nph = 3;
            else nph = 0;
         end else if (m_phase == 0) begin
            if (eff[0] || eff[1]) begin
               m_sel = (eff[1] && (!eff[0] || m_cnt == LIMIT)) ? 1 : 0;
               nph = 1;
            end
         end else if (m_phase == 1) begin
            if (gnt) nph = 2;
         end else if (done) begin
            nph = 0;
         end
         if (!m_full[1] || flush) m_cnt = 0;
         if (flush) begin
            m_full[0] = 0; m_full[1] = 0;
         end else begin
            if (fin) m_full[m_sel] = 0;
            if (cap[0]) begin m_full[0] = 1; m_va[0] = dva; m_as[0] = das; m_st = dst; end
            if (cap[1]) begin m_full[1] = 1; m_va[1] = iva; m_as[1] = ias; end
         end
         m_phase = nph;
      end
   end

   // Every-cycle compare of all outputs against the model, off the active edge.
   always @(negedge clk) begin : compare
      logic [63:0] exp_v, act_v;
      bit req, rsp;
      if (m_on) begin
         req = (m_phase == 1);
         rsp = (m_phase == 2) && done && !flush;
         exp_v = '0;
         exp_v[VLEN-1:0] = req ? m_va[m_sel] : '0;
         exp_v[48:39] = {!m_full[1] && !flush, !m_full[0] && !flush, req,
                         req && m_sel == 1, req && m_sel == 0 && m_st,
                         req ? m_as[m_sel] : 1'b0,
                         rsp && m_sel == 1, rsp && m_sel == 0, rsp && werr, m_phase != 0};
         act_v = '0;
         act_v[VLEN-1:0] = wva;
         act_v[48:39] = {irdy, drdy, wreq, winstr, wstore, was, ires, dres, rerr, busy};
         check("cycle_outputs", act_v, exp_v);
         if (ires) i_cnt++;
         if (dres) d_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   // Wait for a walk request, grant it, return done after lat cycles.
   task automatic serve(input int lat, input bit err, input bit exp_instr, input string name);
      int n = 0;
      while (!wreq && n < 20) begin tick(); n++; end
      check({name, "_req"}, 64'(wreq), 64'd1);
      if (!wreq) return;
      check({name, "_instr"}, 64'(winstr), 64'(exp_instr));
      gnt = 1'b1; tick(); gnt = 1'b0;
      repeat (lat) tick();
      done = 1'b1; werr = err; #1;
      check({name, "_resp"}, 64'(exp_instr ? ires : dres), 64'd1);
      check({name, "_err"}, 64'(rerr), 64'(err));
      tick(); done = 1'b0; werr = 1'b0;
   endtask

   initial begin
      tick(); tick();
      rst = 1'b0; #1;
      // reset state
      check("rst_ready", {62'd0, irdy, drdy}, 64'h3);
      check("rst_busy_req", {62'd0, busy, wreq}, 64'h0);

      // ITLB-only flow
      iv = 1'b1; iva = 39'h40_0000_1000; ias = 1'b1;
      tick(); iv = 1'b0; #1;
      check("itlb_req", {62'd0, wreq, winstr}, 64'h3);
      check("itlb_vaddr", 64'(wva), 64'h40_0000_1000);
      check("itlb_asid", 64'(was), 64'd1);
      gnt = 1'b1; tick(); gnt = 1'b0;
      repeat (4) tick();
      done = 1'b1; #1;
      check("itlb_resp", {61'd0, ires, dres, rerr}, 64'h4);
      tick(); done = 1'b0; #1;
      check("itlb_ready_after", {62'd0, irdy, ires}, 64'h2);

      // simultaneous misses: DTLB first, then ITLB
      i_cnt = 0; d_cnt = 0;
      iv = 1'b1; iva = 39'h00_0000_2000; ias = 1'b0;
      dv = 1'b1; dva = 39'h12_3456_7000; das = 1'b1; dst = 1'b1;
      tick(); iv = 1'b0; dv = 1'b0; dst = 1'b0; #1;
      check("both_store", {62'd0, wstore, winstr}, 64'h2);
      check("both_dvaddr", 64'(wva), 64'h12_3456_7000);
      serve(3, 1'b1, 1'b0, "both_d");
      serve(2, 1'b0, 1'b1, "both_i");
      repeat (3) tick();
      check("both_counts", 64'({i_cnt[15:0], d_cnt[15:0]}), 64'h0001_0001);

      // starvation: ITLB pending, DTLB refilled after every completion
      i_cnt = 0; d_cnt = 0;
      iv = 1'b1; iva = 39'h00_0000_3000;
      dv = 1'b1; dva = 39'h00_0000_4000;
      tick(); iv = 1'b0; dv = 1'b0;
      for (int k = 0; k < 4; k++) begin
         serve(1, 1'b0, 1'b0, "starve_d");
         dv = 1'b1; dva = dva + 39'h1000;
         tick(); dv = 1'b0;
      end
      #1;
      check("starve_cnt_full", 64'(dut.starve_cnt_q), 64'd4);
      check("starve_fifth_instr", {62'd0, wreq, winstr}, 64'h3);
      gnt = 1'b1; tick(); gnt = 1'b0; #1;
      check("starve_cnt_cleared", 64'(dut.starve_cnt_q), 64'd0);
      tick(); done = 1'b1; #1;
      check("starve_i_resp", 64'(ires), 64'd1);
      tick(); done = 1'b0;
      serve(1, 1'b0, 1'b0, "starve_last_d");
      repeat (2) tick();
      check("starve_counts", 64'({i_cnt[15:0], d_cnt[15:0]}), 64'h0001_0005);

      // flush in REQ without grant
      i_cnt = 0; d_cnt = 0;
      dv = 1'b1; dva = 39'h00_0000_5000;
      tick(); dv = 1'b0;
      flush = 1'b1; tick(); flush = 1'b0; #1;
      check("flreq_idle", {61'd0, wreq, busy, ires | dres}, 64'h0);
      check("flreq_ready", {62'd0, irdy, drdy}, 64'h3);
      repeat (3) tick();
      check("flreq_no_walk", 64'(wreq), 64'd0);

      // flush in WALK, drain, then a fresh DTLB miss
      dv = 1'b1; dva = 39'h00_0000_6000;
      tick(); dv = 1'b0;
      gnt = 1'b1; tick(); gnt = 1'b0;
      flush = 1'b1; tick(); flush = 1'b0; #1;
      check("flwalk_drain_busy", {62'd0, busy, wreq}, 64'h2);
      repeat (2) tick();
      done = 1'b1; werr = 1'b1; #1;
      check("flwalk_no_resp", {61'd0, ires, dres, rerr}, 64'h0);
      tick(); done = 1'b0; werr = 1'b0; #1;
      check("flwalk_idle", 64'(busy), 64'd0);
      dv = 1'b1; dva = 39'h00_0000_7000;
      tick(); dv = 1'b0;
      serve(2, 1'b0, 1'b0, "flwalk_new");

      // flush on the grant cycle, then flush with done in WALK
      dv = 1'b1; tick(); dv = 1'b0;
      gnt = 1'b1; flush = 1'b1; tick(); gnt = 1'b0; flush = 1'b0; #1;
      check("flgnt_drain", {62'd0, busy, wreq}, 64'h2);
      done = 1'b1; tick(); done = 1'b0;
      iv = 1'b1; tick(); iv = 1'b0;
      gnt = 1'b1; tick(); gnt = 1'b0;
      done = 1'b1; flush = 1'b1; #1;
      check("fldone_no_resp", {62'd0, ires, dres}, 64'h0);
      tick(); done = 1'b0; flush = 1'b0; #1;
      check("fldone_idle", 64'(busy), 64'd0);
      check("flush_counts", 64'({i_cnt[15:0], d_cnt[15:0]}), 64'h0000_0001);

      // reset during WALK with both slots full
      iv = 1'b1; dv = 1'b1;
      tick(); iv = 1'b0; dv = 1'b0;
      gnt = 1'b1; tick(); gnt = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0; #1;
      check("rst_walk_state", {61'd0, irdy, drdy, busy}, 64'h6);
      done = 1'b1; #1;
      check("rst_late_done", {62'd0, ires, dres}, 64'h0);
      tick(); done = 1'b0;
      repeat (3) tick();
      check("rst_stays_idle", 64'(busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
